// File: rtl/core_pkg.sv
// Shared core definitions: ALUop encodings, the ID/EX control bundle and the default datapath width.
package core_pkg;

   localparam int unsigned XLEN_DEFAULT = 32;

   localparam logic [1:0] ALUOP_ADD    = 2'b00;
   localparam logic [1:0] ALUOP_BRANCH = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
   localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

   typedef struct packed {
      logic       reg_write;
      logic       alu_src;
      logic       mem_write;
      logic       mem_read;
      logic       branch;
      logic       mem_to_reg;
      logic [1:0] alu_op;
   } ctrl_t;

endpackage

// File: rtl/id_ex_reg_load_use_detect.sv
// Load-use hazard detector: flags an ID instruction reading the destination of a load in EX.
// Only built when HAZARD_DETECT_EN is defined.
`ifdef HAZARD_DETECT_EN
module load_use_detect (
   input  logic       ex_valid,
   input  logic       ex_mem_read,
   input  logic [4:0] ex_rd,
   input  logic       id_valid,
   input  logic       id_uses_rs1,
   input  logic       id_uses_rs2,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   output logic       ld_use
);

   logic rs1_hit;
   logic rs2_hit;

   always_comb begin
      rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
      rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);
      // x0 is never really written, so a load to x0 cannot create a hazard
      ld_use  = ex_valid && ex_mem_read && (ex_rd != 5'd0) && id_valid && (rs1_hit || rs2_hit);
   end

endmodule
`endif

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with bubble insertion, flush, downstream stall and load-use stall.
// HAZARD_DETECT_EN builds the load-use detector; otherwise hazard_stall is tied low.
module id_ex_reg
   import core_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            id_valid,
   input  logic [XLEN-1:0] id_pc,
   input  logic [XLEN-1:0] id_rs1_data,
   input  logic [XLEN-1:0] id_rs2_data,
   input  logic [XLEN-1:0] id_imm,
   input  logic [4:0]      id_rs1,
   input  logic [4:0]      id_rs2,
   input  logic [4:0]      id_rd,
   input  logic            id_uses_rs1,
   input  logic            id_uses_rs2,
   input  logic [2:0]      id_funct3,
   input  logic            id_funct7b5,
   input  logic            id_reg_write,
   input  logic            id_alu_src,
   input  logic            id_mem_write,
   input  logic            id_mem_read,
   input  logic            id_branch,
   input  logic            id_mem_to_reg,
   input  logic [1:0]      id_alu_op,
   input  logic            stall_ext,
   input  logic            flush,
   output logic            ex_valid,
   output logic [XLEN-1:0] ex_pc,
   output logic [XLEN-1:0] ex_rs1_data,
   output logic [XLEN-1:0] ex_rs2_data,
   output logic [XLEN-1:0] ex_imm,
   output logic [4:0]      ex_rs1,
   output logic [4:0]      ex_rs2,
   output logic [4:0]      ex_rd,
   output logic            ex_uses_rs1,
   output logic            ex_uses_rs2,
   output logic [2:0]      ex_funct3,
   output logic            ex_funct7b5,
   output logic            ex_reg_write,
   output logic            ex_alu_src,
   output logic            ex_mem_write,
   output logic            ex_mem_read,
   output logic            ex_branch,
   output logic            ex_mem_to_reg,
   output logic [1:0]      ex_alu_op,
   output logic            hazard_stall
);

   ctrl_t           ctrl_d, ctrl_q;
   logic            valid_d, valid_q;
   logic [XLEN-1:0] pc_d, pc_q;
   logic [XLEN-1:0] rs1_data_d, rs1_data_q;
   logic [XLEN-1:0] rs2_data_d, rs2_data_q;
   logic [XLEN-1:0] imm_d, imm_q;
   logic [4:0]      rs1_d, rs1_q;
   logic [4:0]      rs2_d, rs2_q;
   logic [4:0]      rd_d, rd_q;
   logic            uses_rs1_d, uses_rs1_q;
   logic            uses_rs2_d, uses_rs2_q;
   logic [2:0]      funct3_d, funct3_q;
   logic            funct7b5_d, funct7b5_q;
   ctrl_t           id_ctrl;
   logic            ld_use;

`ifdef HAZARD_DETECT_EN
   load_use_detect u_load_use_detect (
      .ex_valid    (valid_q),
      .ex_mem_read (ctrl_q.mem_read),
      .ex_rd       (rd_q),
      .id_valid    (id_valid),
      .id_uses_rs1 (id_uses_rs1),
      .id_uses_rs2 (id_uses_rs2),
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .ld_use      (ld_use)
   );
`else
   assign ld_use = 1'b0;
`endif

   // Independent of stall_ext so IF/ID holds while MEM is stalled too
   assign hazard_stall = ld_use & ~flush;

   always_comb begin
      id_ctrl = '{reg_write:  id_reg_write,
                  alu_src:    id_alu_src,
                  mem_write:  id_mem_write,
                  mem_read:   id_mem_read,
                  branch:     id_branch,
                  mem_to_reg: id_mem_to_reg,
                  alu_op:     id_alu_op};

      ctrl_d     = ctrl_q;
      valid_d    = valid_q;
      pc_d       = pc_q;
      rs1_data_d = rs1_data_q;
      rs2_data_d = rs2_data_q;
      imm_d      = imm_q;
      rs1_d      = rs1_q;
      rs2_d      = rs2_q;
      rd_d       = rd_q;
      uses_rs1_d = uses_rs1_q;
      uses_rs2_d = uses_rs2_q;
      funct3_d   = funct3_q;
      funct7b5_d = funct7b5_q;

      if (!stall_ext) begin
         pc_d       = id_pc;
         rs1_data_d = id_rs1_data;
         rs2_data_d = id_rs2_data;
         imm_d      = id_imm;
         rs1_d      = id_rs1;
         rs2_d      = id_rs2;
         rd_d       = id_rd;
         uses_rs1_d = id_uses_rs1;
         uses_rs2_d = id_uses_rs2;
         funct3_d   = id_funct3;
         funct7b5_d = id_funct7b5;
         // Flush, load-use and an empty ID slot all become a bubble with control cleared
         if (flush || ld_use || !id_valid) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
         end else begin
            valid_d = 1'b1;
            ctrl_d  = id_ctrl;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_q     <= '0;
         valid_q    <= 1'b0;
         pc_q       <= '0;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
         imm_q      <= '0;
         rs1_q      <= '0;
         rs2_q      <= '0;
         rd_q       <= '0;
         uses_rs1_q <= 1'b0;
         uses_rs2_q <= 1'b0;
         funct3_q   <= '0;
         funct7b5_q <= 1'b0;
      end else begin
         ctrl_q     <= ctrl_d;
         valid_q    <= valid_d;
         pc_q       <= pc_d;
         rs1_data_q <= rs1_data_d;
         rs2_data_q <= rs2_data_d;
         imm_q      <= imm_d;
         rs1_q      <= rs1_d;
         rs2_q      <= rs2_d;
         rd_q       <= rd_d;
         uses_rs1_q <= uses_rs1_d;
         uses_rs2_q <= uses_rs2_d;
         funct3_q   <= funct3_d;
         funct7b5_q <= funct7b5_d;
      end
   end

   assign ex_valid      = valid_q;
   assign ex_pc         = pc_q;
   assign ex_rs1_data   = rs1_data_q;
   assign ex_rs2_data   = rs2_data_q;
   assign ex_imm        = imm_q;
   assign ex_rs1        = rs1_q;
   assign ex_rs2        = rs2_q;
   assign ex_rd         = rd_q;
   assign ex_uses_rs1   = uses_rs1_q;
   assign ex_uses_rs2   = uses_rs2_q;
   assign ex_funct3     = funct3_q;
   assign ex_funct7b5   = funct7b5_q;
   assign ex_reg_write  = ctrl_q.reg_write;
   assign ex_alu_src    = ctrl_q.alu_src;
   assign ex_mem_write  = ctrl_q.mem_write;
   assign ex_mem_read   = ctrl_q.mem_read;
   assign ex_branch     = ctrl_q.branch;
   assign ex_mem_to_reg = ctrl_q.mem_to_reg;
   assign ex_alu_op     = ctrl_q.alu_op;

endmodule

// File: tb/tb_id_ex_reg.sv
// Bench for id_ex_reg: directed pipeline scenarios then random traffic against a reference model.
// Follows HAZARD_DETECT_EN the same way the design does.
module tb_id_ex_reg;

`ifdef HAZARD_DETECT_EN
   localparam bit HazEn = 1'b1;
`else
   localparam bit HazEn = 1'b0;
`endif

   typedef struct packed {
      logic        valid;
      logic        reg_write;
      logic        alu_src;
      logic        mem_write;
      logic        mem_read;
      logic        branch;
      logic        mem_to_reg;
      logic [1:0]  alu_op;
      logic [31:0] pc;
      logic [31:0] rs1_data;
      logic [31:0] rs2_data;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        uses_rs1;
      logic        uses_rs2;
      logic [2:0]  funct3;
      logic        funct7b5;
   } stage_t;

   logic   clk = 1'b0;
   logic   rst;
   logic   stall_ext;
   logic   flush;
   stage_t id;
   stage_t exp_ex;
   stage_t obs;

   logic        ex_valid, ex_uses_rs1, ex_uses_rs2, ex_funct7b5;
   logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
   logic [4:0]  ex_rs1, ex_rs2, ex_rd;
   logic [2:0]  ex_funct3;
   logic        ex_reg_write, ex_alu_src, ex_mem_write, ex_mem_read, ex_branch, ex_mem_to_reg;
   logic [1:0]  ex_alu_op;
   logic        hazard_stall;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   id_ex_reg #(.XLEN(32)) dut (
      .clk           (clk),
      .rst           (rst),
      .id_valid      (id.valid),
      .id_pc         (id.pc),
      .id_rs1_data   (id.rs1_data),
      .id_rs2_data   (id.rs2_data),
      .id_imm        (id.imm),
      .id_rs1        (id.rs1),
      .id_rs2        (id.rs2),
      .id_rd         (id.rd),
      .id_uses_rs1   (id.uses_rs1),
      .id_uses_rs2   (id.uses_rs2),
      .id_funct3     (id.funct3),
      .id_funct7b5   (id.funct7b5),
      .id_reg_write  (id.reg_write),
      .id_alu_src    (id.alu_src),
      .id_mem_write  (id.mem_write),
      .id_mem_read   (id.mem_read),
      .id_branch     (id.branch),
      .id_mem_to_reg (id.mem_to_reg),
      .id_alu_op     (id.alu_op),
      .stall_ext     (stall_ext),
      .flush         (flush),
      .ex_valid      (ex_valid),
      .ex_pc         (ex_pc),
      .ex_rs1_data   (ex_rs1_data),
      .ex_rs2_data   (ex_rs2_data),
      .ex_imm        (ex_imm),
      .ex_rs1        (ex_rs1),
      .ex_rs2        (ex_rs2),
      .ex_rd         (ex_rd),
      .ex_uses_rs1   (ex_uses_rs1),
      .ex_uses_rs2   (ex_uses_rs2),
      .ex_funct3     (ex_funct3),
      .ex_funct7b5   (ex_funct7b5),
      .ex_reg_write  (ex_reg_write),
      .ex_alu_src    (ex_alu_src),
      .ex_mem_write  (ex_mem_write),
      .ex_mem_read   (ex_mem_read),
      .ex_branch     (ex_branch),
      .ex_mem_to_reg (ex_mem_to_reg),
      .ex_alu_op     (ex_alu_op),
      .hazard_stall  (hazard_stall)
   );

   function automatic stage_t get_obs();
      stage_t s;
      s = '{valid: ex_valid, reg_write: ex_reg_write, alu_src: ex_alu_src,
            mem_write: ex_mem_write, mem_read: ex_mem_read, branch: ex_branch,
            mem_to_reg: ex_mem_to_reg, alu_op: ex_alu_op, pc: ex_pc,
            rs1_data: ex_rs1_data, rs2_data: ex_rs2_data, imm: ex_imm, rs1: ex_rs1,
            rs2: ex_rs2, rd: ex_rd, uses_rs1: ex_uses_rs1, uses_rs2: ex_uses_rs2,
            funct3: ex_funct3, funct7b5: ex_funct7b5};
      return s;
   endfunction

   // Reference model: does the instruction in ID read a register a load in EX is still fetching?
   function automatic bit model_ld_use(stage_t ex, stage_t nid);
      if (!HazEn || !ex.valid || !ex.mem_read || ex.rd == 5'd0 || !nid.valid) return 1'b0;
      return (nid.uses_rs1 && nid.rs1 == ex.rd) || (nid.uses_rs2 && nid.rs2 == ex.rd);
   endfunction

   function automatic stage_t model_next(stage_t ex, stage_t nid, bit st, bit fl);
      stage_t n;
      if (st) return ex;
      n = nid;
      if (fl || model_ld_use(ex, nid) || !nid.valid) begin
         n.valid = 0; n.reg_write = 0; n.alu_src = 0; n.mem_write = 0;
         n.mem_read = 0; n.branch = 0; n.mem_to_reg = 0; n.alu_op = 2'b00;
      end
      return n;
   endfunction

   function automatic stage_t mk(bit v, int r1, int r2, int rd, bit u1, bit u2, bit mr,
                                 bit rw, logic [1:0] op);
      stage_t s;
      s = '0;
      s.valid = v; s.rs1 = 5'(r1); s.rs2 = 5'(r2); s.rd = 5'(rd);
      s.uses_rs1 = u1; s.uses_rs2 = u2; s.mem_read = mr; s.mem_to_reg = mr;
      s.reg_write = rw; s.alu_op = op; s.alu_src = mr;
      s.pc = $urandom; s.rs1_data = $urandom; s.rs2_data = $urandom; s.imm = $urandom;
      s.funct3 = 3'($urandom_range(0, 7));
      return s;
   endfunction

   function automatic stage_t rand_id();
      stage_t s;
      s = mk($urandom_range(0, 99) < 85, $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), 1'($urandom), 1'($urandom), $urandom_range(0, 2) == 0,
             1'($urandom), 2'($urandom_range(0, 3)));
      s.mem_write = 1'($urandom); s.branch = 1'($urandom); s.funct7b5 = 1'($urandom);
      return s;
   endfunction

   task automatic check(string tag, logic [255:0] o, logic [255:0] e);
      n_cmp++;
      assert (o === e) else begin
         n_fail++;
         $error("FAIL %s: observed %0h required %0h", tag, o, e);
      end
   endtask

   // Control and valid are always defined; datapath only matters for a real instruction
   task automatic check_ex(string tag);
      obs = get_obs();
      check({tag, "_ctl"}, 256'(obs[$bits(stage_t)-1 -: 9]), 256'(exp_ex[$bits(stage_t)-1 -: 9]));
      if (exp_ex.valid) check({tag, "_all"}, 256'(obs), 256'(exp_ex));
   endtask

   task automatic step(string tag, stage_t nid, bit st, bit fl);
      @(negedge clk);
      id = nid; stall_ext = st; flush = fl;
      #1;
      check({tag, "_hz"}, 256'(hazard_stall), 256'(model_ld_use(exp_ex, nid) && !fl));
      @(posedge clk);
      exp_ex = model_next(exp_ex, nid, st, fl);
      #1;
      check_ex(tag);
   endtask

   stage_t lw5, add5, lw0, add_rs2;

   initial begin
      rst = 1'b1; stall_ext = 1'b0; flush = 1'b0; id = '0; exp_ex = '0;
      #1;
      check("reset_init", 256'(get_obs()), 256'(0));
      @(negedge clk);
      rst = 1'b0;

      // Plain R-type load
      add5 = mk(1, 5, 6, 7, 1, 1, 0, 1, 2'b10);
      add5.rs1_data = 32'h0000_00AA;
      step("plain", add5, 0, 0);
      check("plain_aluop", 256'(ex_alu_op), 256'(2'b10));
      check("plain_rs1d", 256'(ex_rs1_data), 256'(32'hAA));
      check("plain_valid", 256'({ex_valid, ex_reg_write}), 256'(2'b11));

      // Asynchronous reset mid-cycle with a live instruction in EX
      @(negedge clk);
      #2 rst = 1'b1;
      #1 check("reset_async", 256'(get_obs()), 256'(0));
      exp_ex = '0;
      @(negedge clk);
      rst = 1'b0;
      step("post_rst", add5, 0, 0);

      // Load-use: lw x5 then add reading x5
      lw5 = mk(1, 1, 0, 5, 1, 0, 1, 1, 2'b00);
      step("lu_lw", lw5, 0, 0);
      step("lu_add1", add5, 0, 0);
      step("lu_add2", add5, 0, 0);

      // No false hazard: load to x0, and rs2 matching but unused
      lw0 = mk(1, 1, 0, 0, 1, 0, 1, 1, 2'b00);
      add_rs2 = mk(1, 0, 0, 7, 1, 1, 0, 1, 2'b10);
      step("nf_lw0", lw0, 0, 0);
      step("nf_add0", add_rs2, 0, 0);
      add_rs2 = mk(1, 3, 5, 7, 1, 0, 0, 1, 2'b10);
      step("nf_lw5", lw5, 0, 0);
      step("nf_rs2", add_rs2, 0, 0);

      // Flush wins over load-use; stall_ext with flush holds
      step("fl_lw", lw5, 0, 0);
      step("fl_add", add5, 0, 1);
      step("sf_load", add5, 0, 0);
      step("sf_hold", rand_id(), 1, 1);

      // Load-use while MEM stalls: hold and keep requesting stall
      step("ls_lw", lw5, 0, 0);
      step("ls_hold", add5, 1, 0);
      step("ls_add1", add5, 0, 0);
      step("ls_add2", add5, 0, 0);

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         step("rand", rand_id(), $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 12);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/id_ex_reg.md
# id_ex_reg

ID/EX pipeline register for the five-stage RISC-V core. It sits directly downstream of the ID-stage control decoder and captures the decoder's control bundle (RegWrite, ALUSrc, MemWrite, MemRead, Branch, MemToReg, ALUop) plus operands and register indices for EX. It also generates the load-use stall toward IF/ID, inserts bubbles, and honours EX-stage flush and downstream stall.

## Interface
- XLEN, 32, datapath width of PC, operands and immediate.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_pc, id_rs1_data, id_rs2_data, id_imm  in  XLEN each  ID-stage datapath values.
- id_rs1, id_rs2, id_rd  in  5 each  register indices.
- id_uses_rs1, id_uses_rs2  in  1 each  instruction actually reads rs1/rs2.
- id_funct3  in  3  funct3 field.
- id_funct7b5  in  1  instruction bit 30.
- id_reg_write, id_alu_src, id_mem_write, id_mem_read, id_branch, id_mem_to_reg  in  1 each  decoder control outputs.
- id_alu_op  in  2  decoder ALUop.
- stall_ext  in  1  downstream (MEM) stall; hold the register.
- flush  in  1  taken branch resolved in EX; kill the instruction entering EX.
- ex_* (each id_* field above, same widths)  out  registered copies.
- ex_valid  out  1  EX holds a real instruction.
- hazard_stall  out  1  combinational; PC and IF/ID must hold this cycle.

## Operation
- Per-edge update priority: rst > stall_ext > flush > load-use bubble > load.
- rst: all ex_* outputs and ex_valid go to 0 immediately; no wait for an edge.
- stall_ext=1: every register holds. flush and bubble are ignored that edge.
- flush=1 (stall_ext=0): load a bubble.
- Bubble: ex_valid=0 and all six control bits plus ex_alu_op cleared to 0. Datapath and index fields still capture their id_* inputs; their values are don't-care and not checked.
- Load: all fields capture their id_* inputs. ex_valid=id_valid. When id_valid=0, control is cleared exactly as for a bubble.
- Load-use detect: ld_use = ex_valid & ex_mem_read & (ex_rd≠0) & id_valid & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- hazard_stall = ld_use & ~flush. When ld_use=1 and flush=0, a bubble is loaded on the next edge.
- After one bubble, ex_mem_read=0, so ld_use clears and the held ID instruction loads on the following edge. Every load-use case costs exactly one stall cycle.
- ld_use with stall_ext=1: the register holds and hazard_stall stays 1.
- rd=x0 never creates a hazard.

## Timing
- Latency: 1 cycle, ID inputs to ex_* outputs.
- hazard_stall is a pure combinational function of the current ex_* registers and the id_* inputs and flush. It has no dependency on stall_ext.
- All ex_* outputs come directly from flops; there is no combinational path from inputs to ex_*.
- Reset deasserted mid-stream: the first edge after deassertion performs a normal load.

## Configuration
- HAZARD_DETECT_EN defined: ld_use logic is built, and hazard_stall and automatic bubble insertion behave as described above.
- HAZARD_DETECT_EN undefined: ld_use is tied 0 and hazard_stall is tied 0. Only flush, stall_ext and id_valid=0 create bubbles; the software/compiler guarantees load-use spacing.

## Structure
- Shared package (core_pkg):
  - ALUop constants: ALUOP_ADD=2'b00, ALUOP_BRANCH=2'b01, ALUOP_RTYPE=2'b10, ALUOP_ITYPE=2'b11.
  - Packed struct ctrl_t bundling the seven control fields; this block stores ctrl_t as one register.
  - XLEN default.
- One sub-module, load_use_detect: combinational, takes the ex_* and id_* indices and flags and outputs ld_use. It is compiled only under HAZARD_DETECT_EN.

## Test plan
- Reset: assert rst mid-cycle with ex_valid=1 and ex_reg_write=1 -> all ex_* and ex_valid read 0 before the next clk edge.
- Plain load: id_valid=1, R-type control, id_alu_op=2'b10, id_rs1_data=0x0000_00AA -> after one edge ex_alu_op=2'b10, ex_reg_write=1, ex_rs1_data=0xAA, ex_valid=1.
- Load-use: EX holds lw x5 (ex_mem_read=1, ex_rd=5); ID holds add with id_rs1=5 and id_uses_rs1=1 -> hazard_stall=1 that cycle; next edge loads a bubble (ex_valid=0, controls 0); then hazard_stall=0 and the add loads on the following edge.
- No false hazard: same as the load-use case but ex_rd=0, or id_uses_rs2=0 with id_rs2=5 and id_rs1≠5 -> hazard_stall=0 and the add loads with no bubble.
- Flush vs hazard: flush=1 while ld_use is true -> hazard_stall=0 and a bubble is loaded. With stall_ext=1 and flush=1 simultaneously -> the register holds its previous contents unchanged.
- Macro off: build without HAZARD_DETECT_EN and rerun the load-use scenario -> hazard_stall stays 0 and the add loads on the first edge.
